dmem_lsu_master: RTL and testbench
==================================

# dmem_lsu_master

Bus initiator for the SoC single-port data-memory interface: the CPU-side counterpart of the data RAM. Accepts one byte, halfword or word load/store at a time from the core, generates the word address, byte enables and replicated write data, and handles the busy/ack handshake. It returns aligned, sign- or zero-extended load data or an error. It sits between the core's memory stage and the data RAM or peripheral bus.

## Interface
- p_timeout, 16: max cycles in ISSUE+WAIT before error response; 0 disables timeout
- i_clk  in  1  global clock
- i_rst  in  1  global reset, synchronous, active-low
- i_req_valid  in  1  core request strobe
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- i_req_unsigned  in  1  zero-extend load data
- i_req_wdata  in  32  store data, LSB-aligned
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned, illegal size or timeout
- o_addr  out  30  word address [31:2]
- o_be  out  4  byte enables
- o_wr_en  out  1  write strobe
- o_wr_data  out  32  write data
- o_rd_en  out  1  read strobe
- i_rd_data  in  32  read data, valid with i_ack
- i_busy  in  1  responder cannot accept this cycle
- i_ack  in  1  transfer done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch the request.
  - Misaligned or illegal request: go to RESP with err=1. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. Illegal means size=3.
  - Otherwise go to ISSUE.
- ISSUE: assert o_rd_en or o_wr_en with registered o_addr, o_be and o_wr_data.
  - Acceptance happens in a cycle where the strobe is high and i_busy=0.
  - If i_busy=1, hold all bus outputs unchanged and stay in ISSUE.
  - On acceptance, go to WAIT; the strobe drops on the next cycle.
- WAIT: on i_ack, capture i_rd_data (loads only) and go to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → addr[1]?4'b1100:4'b0011; word → 4'b1111.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Read data:
  - Shift right by 8·addr[1:0].
  - Truncate to the request size.
  - Sign-extend from bit 7 or 15 unless i_req_unsigned. Word loads are passed through unchanged.
- Timeout:
  - A counter is cleared on leaving IDLE and increments every cycle in ISSUE or WAIT.
  - When it reaches p_timeout, go to RESP with err=1 and rdata=0. Bus strobes drop immediately.
- i_ack in IDLE, ISSUE or RESP is ignored. A late ack after a timeout is ignored.

## Timing
- Reset (i_rst=0 at a clock edge): state IDLE, counter 0. Reset values: o_rd_en=0, o_wr_en=0, o_be=0, o_addr=0, o_wr_data=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready=1 from the first cycle after reset.
- Reset mid-transfer aborts the access with no response. A pending ack is dropped.
- Nominal path, with request accepted at cycle T and i_busy=0:
  - Strobe high in T+1.
  - Ack at T+2 for a 1-cycle RAM.
  - o_rsp_valid at T+3.
  - Next request can be accepted at T+4.
- Each busy cycle adds one cycle of latency.
- Error path: a misaligned request at T gives o_rsp_valid with err at T+1. No bus strobe is asserted.
- A request arriving while o_req_ready=0 is not accepted. The core holds it.

## Structure
- Package dmem_lsu_pkg contains:
  - typedef enum for size (SZ_BYTE, SZ_HALF, SZ_WORD)
  - typedef enum for FSM states
  - function misaligned(size, addr[1:0])
- Sub-module dmem_lsu_align, purely combinational. It takes size, addr[1:0], unsigned, wdata and rdata, and produces be, aligned wdata and extended rdata. It is reused by the instruction-fetch path.
- Top level holds the FSM, the request latch, the timeout counter and the registered bus outputs.

## Test plan
- Store byte 0xA5 to 0x10000003:
  - o_addr=0x04000000, o_be=4'b1000, o_wr_data=0xA5A5A5A5.
  - Response at T+3 with err=0.
- Load half, signed, from 0x10000002 with the RAM word = 0x8001_1234: o_rsp_rdata=0xFFFF8001. With unsigned: 0x00008001.
- Hold i_busy=1 for 3 cycles during ISSUE: bus outputs stable, single acceptance, response at T+6.
- Load word from 0x10000002: o_rsp_err=1 at T+1, no o_rd_en pulse. Size=3 gives the same result.
- p_timeout=4 with i_ack never asserted: err response after 4 ISSUE/WAIT cycles, rdata=0. A later i_ack is ignored.
- Assert i_rst=0 while in WAIT: all outputs at reset values the next cycle, no o_rsp_valid, o_req_ready=1 after release.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store initiator.
package dmem_lsu_pkg;

    // Access size encoding as presented by the core; 2'd3 is not a legal size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Request sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // True when the low address bits do not suit the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering: byte enables, replicated store data and extended load data.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;

    // Lane selection and sign/zero extension, all a function of size and offset.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        be        = 4'b0000;
        wdata_al  = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                        : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                        : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_al  = 32'h0000_0000;
                rdata_ext = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu_master.sv
// Single-outstanding load/store initiator on the busy/ack data-memory bus.
module dmem_lsu_master
    import dmem_lsu_pkg::*;
#(
    parameter int p_timeout = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [29:0] o_addr,
    output logic [3:0]  o_be,
    output logic        o_wr_en,
    output logic [31:0] o_wr_data,
    output logic        o_rd_en,
    input  logic [31:0] i_rd_data,
    input  logic        i_busy,
    input  logic        i_ack
);

    localparam int            TW       = (p_timeout > 1) ? $clog2(p_timeout + 1) : 1;
    localparam bit            TO_EN    = (p_timeout != 0);
    localparam logic [TW-1:0] TO_LIMIT = TW'(p_timeout);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    state_e        state_r, state_s;
    logic [TW-1:0] cnt_r;
    logic          req_we_r;
    logic [1:0]    req_addr_lo_r;
    logic [1:0]    req_size_r;
    logic          req_unsigned_r;

    logic          idle_s, req_bad_s, timeout_s;
    logic          issue_s, drop_s, go_resp_s, resp_err_s, resp_data_s;
    logic [1:0]    al_size_s, al_addr_lo_s;
    logic          al_unsigned_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_al_s, rdata_ext_s;

    assign idle_s      = (state_r == ST_IDLE);
    assign o_req_ready = idle_s;
    assign req_bad_s   = misaligned(i_req_size, i_req_addr[1:0]) || (i_req_size == SIZE_ILLEGAL);
    assign timeout_s   = TO_EN && ((cnt_r + CNT_ONE) == TO_LIMIT);

    // The aligner sees the incoming request while idle (to build bus outputs)
    // and the latched request afterwards (to extend the returned load data).
    assign al_size_s     = idle_s ? i_req_size          : req_size_r;
    assign al_addr_lo_s  = idle_s ? i_req_addr[1:0]     : req_addr_lo_r;
    assign al_unsigned_s = idle_s ? i_req_unsigned      : req_unsigned_r;

    dmem_lsu_align u_align (
        .size        (al_size_s),
        .addr_lo     (al_addr_lo_s),
        .is_unsigned (al_unsigned_s),
        .wdata       (i_req_wdata),
        .rdata       (i_rd_data),
        .be          (be_s),
        .wdata_al    (wdata_al_s),
        .rdata_ext   (rdata_ext_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode; timeout outranks bus progress.
    always_comb begin
        state_s     = state_r;
        issue_s     = 1'b0;
        drop_s      = 1'b0;
        go_resp_s   = 1'b0;
        resp_err_s  = 1'b0;
        resp_data_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid && req_bad_s) begin
                    state_s    = ST_RESP;
                    go_resp_s  = 1'b1;
                    resp_err_s = 1'b1;
                end else if (i_req_valid) begin
                    state_s = ST_ISSUE;
                    issue_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timeout_s) begin
                    state_s    = ST_RESP;
                    drop_s     = 1'b1;
                    go_resp_s  = 1'b1;
                    resp_err_s = 1'b1;
                end else if (!i_busy) begin
                    state_s = ST_WAIT;
                    drop_s  = 1'b1;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (timeout_s) begin
                    state_s    = ST_RESP;
                    go_resp_s  = 1'b1;
                    resp_err_s = 1'b1;
                end else if (i_ack) begin
                    state_s     = ST_RESP;
                    go_resp_s   = 1'b1;
                    resp_data_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Timeout counter: zero while idle, counts every ISSUE/WAIT cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_r <= '0;
        end else if (idle_s) begin
            cnt_r <= '0;
        end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request latch, captured on every accepted request.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            req_we_r       <= 1'b0;
            req_addr_lo_r  <= 2'b00;
            req_size_r     <= 2'b00;
            req_unsigned_r <= 1'b0;
        end else if (idle_s && i_req_valid) begin
            req_we_r       <= i_req_we;
            req_addr_lo_r  <= i_req_addr[1:0];
            req_size_r     <= i_req_size;
            req_unsigned_r <= i_req_unsigned;
        end else begin
            req_we_r       <= req_we_r;
            req_addr_lo_r  <= req_addr_lo_r;
            req_size_r     <= req_size_r;
            req_unsigned_r <= req_unsigned_r;
        end
    end

    // Registered bus outputs: loaded on issue, strobes cleared on acceptance or timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_addr    <= 30'h0000_0000;
            o_be      <= 4'b0000;
            o_wr_data <= 32'h0000_0000;
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
        end else if (issue_s) begin
            o_addr    <= i_req_addr[31:2];
            o_be      <= be_s;
            o_wr_data <= wdata_al_s;
            o_wr_en   <= i_req_we;
            o_rd_en   <= ~i_req_we;
        end else if (drop_s) begin
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
        end else begin
            o_wr_en   <= o_wr_en;
            o_rd_en   <= o_rd_en;
        end
    end

    // Response pulse; data is non-zero only for an acked load.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 32'h0000_0000;
        end else begin
            o_rsp_valid <= go_resp_s;
            o_rsp_err   <= resp_err_s;
            o_rsp_rdata <= (resp_data_s && !req_we_r) ? rdata_ext_s : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Self-checking bench for dmem_lsu_master: vector table, scoreboard and corner sequences.
module tb_dmem_lsu_master;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] ram;
        logic [29:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_we, req_uns, busy;
    logic        ack = 1'b0;
    logic [31:0] rd_data = 32'h0;
    logic [31:0] req_addr, req_wdata, ram_word;
    logic [1:0]  req_size;
    logic        t_req_valid, t_ack;

    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_wr_en, o_rd_en;
    logic [31:0] o_rsp_rdata, o_wr_data;
    logic [29:0] o_addr;
    logic [3:0]  o_be;
    logic        t_req_ready, t_rsp_valid, t_rsp_err, t_wr_en, t_rd_en;
    logic [31:0] t_rsp_rdata, t_wr_data;
    logic [29:0] t_addr;
    logic [3:0]  t_be;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   acc_count = 0;
    logic pend_acc = 1'b0;
    rsp_t sb_q[$];
    vec_t vecs[12];

    dmem_lsu_master #(.p_timeout(16)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_addr(o_addr), .o_be(o_be),
        .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en), .i_rd_data(rd_data),
        .i_busy(busy), .i_ack(ack)
    );

    dmem_lsu_master #(.p_timeout(4)) t_dut (
        .i_clk(clk), .i_rst(rst_n), .i_req_valid(t_req_valid), .o_req_ready(t_req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(t_rsp_valid),
        .o_rsp_rdata(t_rsp_rdata), .o_rsp_err(t_rsp_err), .o_addr(t_addr), .o_be(t_be),
        .o_wr_en(t_wr_en), .o_wr_data(t_wr_data), .o_rd_en(t_rd_en), .i_rd_data(rd_data),
        .i_busy(busy), .i_ack(t_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One-cycle RAM: sees acceptance at a rising edge, acks during the next cycle.
    always @(posedge clk) begin
        pend_acc = (o_rd_en | o_wr_en) & ~busy;
        if ((o_rd_en | o_wr_en) & ~busy) acc_count++;
    end

    always @(negedge clk) begin
        ack     = pend_acc;
        rd_data = pend_acc ? ram_word : 32'h0BAD_F00D;
    end

    // Scoreboard: every response pulse of the main DUT must match the queue head.
    always @(negedge clk) begin
        rsp_t e;
        if (o_rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got response err=%b rdata=%h, expected none", o_rsp_err, o_rsp_rdata);
            end else begin
                e = sb_q.pop_front();
                chk("sb_err", 32'(o_rsp_err), 32'(e.err));
                chk("sb_rdata", o_rsp_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && o_req_ready !== 1'b1; i++) @(negedge clk);
        chk("wait_ready", 32'(o_req_ready), 32'd1);
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        wait_ready();
        ram_word = v.ram;
        drive(v.we, v.addr, v.size, v.uns, v.wdata);
        req_valid = 1'b1;
        sb_q.push_back('{err: v.e_err, rdata: v.e_rdata});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.e_err) begin
            chk($sformatf("v%0d_err_valid", idx), 32'(o_rsp_valid), 32'd1);
            chk($sformatf("v%0d_no_strobe", idx), 32'({o_rd_en, o_wr_en}), 32'd0);
        end else begin
            chk($sformatf("v%0d_strobe", idx), 32'({o_rd_en, o_wr_en}), 32'({~v.we, v.we}));
            chk($sformatf("v%0d_addr", idx), 32'(o_addr), 32'(v.e_addr));
            chk($sformatf("v%0d_be", idx), 32'(o_be), 32'(v.e_be));
            if (v.we) chk($sformatf("v%0d_wdata", idx), o_wr_data, v.e_wdata);
        end
        lat = 1;
        while (o_rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), v.e_err ? 32'd1 : 32'd3);
        @(negedge clk);
        chk($sformatf("v%0d_next_ready", idx), 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        int lat, a0;
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0;
        rst_n = 1'b0; req_valid = 1'b0; t_req_valid = 1'b0; t_ack = 1'b0; busy = 1'b0;
        ram_word = 32'h0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0);

        //           we    addr          sz    uns   wdata         ram           e_addr        e_be     e_wdata       err   e_rdata
        vecs[0]  = '{1'b1, 32'h1000_0003, 2'd0, 1'b0, 32'h0000_00A5, 32'h0,        30'h0400_0000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h1000_0002, 2'd1, 1'b0, 32'h0,         32'h8001_1234, 30'h0400_0000, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001};
        vecs[2]  = '{1'b0, 32'h1000_0002, 2'd1, 1'b1, 32'h0,         32'h8001_1234, 30'h0400_0000, 4'b1100, 32'h0,         1'b0, 32'h0000_8001};
        vecs[3]  = '{1'b0, 32'h2000_0001, 2'd0, 1'b0, 32'h0,         32'h0000_F280, 30'h0800_0000, 4'b0010, 32'h0,         1'b0, 32'hFFFF_FFF2};
        vecs[4]  = '{1'b0, 32'h2000_0000, 2'd0, 1'b1, 32'h0,         32'h1234_5680, 30'h0800_0000, 4'b0001, 32'h0,         1'b0, 32'h0000_0080};
        vecs[5]  = '{1'b0, 32'h3000_0004, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 30'h0C00_0001, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h3000_0006, 2'd1, 1'b0, 32'h0000_BEEF, 32'h5555_5555, 30'h0C00_0001, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h4000_0000, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        30'h1000_0000, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h1000_0002, 2'd2, 1'b0, 32'h0,         32'h0,        30'h0,         4'b0000, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h1000_0000, 2'd3, 1'b0, 32'h0,         32'h0,        30'h0,         4'b0000, 32'h0,         1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h1000_0001, 2'd1, 1'b0, 32'h0,         32'h0,        30'h0,         4'b0000, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h1000_0000, 2'd1, 1'b0, 32'h0,         32'h0000_7FFF, 30'h0400_0000, 4'b0011, 32'h0,         1'b0, 32'h0000_7FFF};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_be", 32'(o_be), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_wr_data", o_wr_data, 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp", {31'd0, o_rsp_err} | o_rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(o_req_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Busy for three edges during ISSUE.
        wait_ready();
        busy = 1'b1;
        ram_word = 32'hCAFE_F00D;
        drive(1'b0, 32'h5000_0000, 2'd2, 1'b0, 32'h0);
        req_valid = 1'b1;
        sb_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
        a0 = acc_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("busy_rd_en_%0d", k), 32'(o_rd_en), 32'd1);
            chk($sformatf("busy_addr_%0d", k), 32'(o_addr), 32'h1400_0000);
            chk($sformatf("busy_be_%0d", k), 32'(o_be), 32'hF);
            if (k == 4) busy = 1'b0;
            else @(negedge clk);
        end
        lat = 4;
        while (o_rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_latency", 32'(lat), 32'd6);
        chk("busy_accepts", 32'(acc_count - a0), 32'd1);
        @(negedge clk);

        // Timeout with no ack on the p_timeout=4 instance, then a late ack.
        drive(1'b0, 32'h6000_0000, 2'd2, 1'b0, 32'h0);
        t_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        chk("to_strobe", 32'(t_rd_en), 32'd1);
        @(negedge clk);
        chk("to_strobe_drop", 32'(t_rd_en), 32'd0);
        lat = 2;
        while (t_rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("to_latency", 32'(lat), 32'd5);
        chk("to_err", 32'(t_rsp_err), 32'd1);
        chk("to_rdata", t_rsp_rdata, 32'd0);
        t_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("to_late_ack_%0d", k), 32'(t_rsp_valid), 32'd0);
        end
        chk("to_ready", 32'(t_req_ready), 32'd1);
        t_ack = 1'b0;

        // Reset while in WAIT, on the same edge as the ack.
        wait_ready();
        ram_word = 32'h1111_1111;
        drive(1'b0, 32'h7000_0000, 2'd2, 1'b0, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wrst_strobe", 32'(o_rd_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("wrst_rd_en", 32'(o_rd_en), 32'd0);
        chk("wrst_be", 32'(o_be), 32'd0);
        chk("wrst_addr", 32'(o_addr), 32'd0);
        chk("wrst_wr_data", o_wr_data, 32'd0);
        chk("wrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("wrst_rsp_rdata", o_rsp_rdata, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("wrst_no_rsp_%0d", k), 32'(o_rsp_valid), 32'd0);
            chk($sformatf("wrst_ready_%0d", k), 32'(o_req_ready), 32'd1);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
